// File: rtl/board_pkg.sv
// board_pkg: shared types and constants for the board overlay.
// Cell state encoding, overlay colours and the VGA counter width.
package board_pkg;

  localparam int VGA_W = 11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_state_t;

  typedef logic [11:0] rgb_t;

  localparam rgb_t C_EMPTY = 12'h08F;
  localparam rgb_t C_SHIP  = 12'h888;
  localparam rgb_t C_HIT   = 12'hF00;
  localparam rgb_t C_MISS  = 12'hFFF;
  localparam rgb_t C_GRID  = 12'h000;

endpackage

// File: rtl/signal_delay.sv
// signal_delay: fixed-length shift-register delay line.
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, clears every stage
//   d_i    - WIDTH-bit input
//   q_o    - d_i delayed by CLK_DEL clocks (combinational pass when CLK_DEL = 0)
module signal_delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (CLK_DEL == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [CLK_DEL-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < CLK_DEL; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[CLK_DEL-1];
  end

endmodule

// File: rtl/board_draw.sv
// board_draw: overlays the 16x16 game board on the VGA stream.
// Reads the board memory every clock from the pixel counters, maps the
// returned cell state to a colour and re-times the VGA signals so every
// output lags its input by MEM_LATENCY+2 clocks.
//   clk, rst                 - pixel clock, async active-low reset
//   vcount_in/hcount_in      - pixel counters
//   *sync_in, *blnk_in       - VGA timing
//   rgb_in                   - upstream colour
//   mem_addr / mem_data      - board memory read port, {row, col} address
//   *_out                    - delayed counters/timing and overlaid colour
module board_draw
  import board_pkg::*;
#(
  parameter int X_POS        = 64,
  parameter int Y_POS        = 64,
  parameter int CELL_SIZE    = 32,
  parameter int X_SIZE       = 16,
  parameter int Y_SIZE       = 16,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2,
  parameter int MEM_LATENCY  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [VGA_W-1:0]                     vcount_in,
  input  logic [VGA_W-1:0]                     hcount_in,
  input  logic                                 vsync_in,
  input  logic                                 hsync_in,
  input  logic                                 vblnk_in,
  input  logic                                 hblnk_in,
  input  logic [11:0]                          rgb_in,
  output logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]                mem_data,
  output logic [VGA_W-1:0]                     vcount_out,
  output logic [VGA_W-1:0]                     hcount_out,
  output logic                                 vsync_out,
  output logic                                 hsync_out,
  output logic                                 vblnk_out,
  output logic                                 hblnk_out,
  output logic [11:0]                          rgb_out
);

  localparam int CELL_SHIFT = $clog2(CELL_SIZE);
  // Relative coordinates only need the in-cell offset plus the cell index;
  // the low bits of a subtraction do not depend on the dropped high bits.
  localparam int RX_W = CELL_SHIFT + X_ADDR_WIDTH;
  localparam int RY_W = CELL_SHIFT + Y_ADDR_WIDTH;
  localparam int TIM_W = 2*VGA_W + 4;
  localparam int PIX_W = 12 + 2;

  localparam logic [VGA_W-1:0] X_LO = VGA_W'(X_POS);
  localparam logic [VGA_W-1:0] X_HI = VGA_W'(X_POS + X_SIZE*CELL_SIZE);
  localparam logic [VGA_W-1:0] Y_LO = VGA_W'(Y_POS);
  localparam logic [VGA_W-1:0] Y_HI = VGA_W'(Y_POS + Y_SIZE*CELL_SIZE);

  // ---------------- stage 1: address and board/grid flags ----------------
  logic [RX_W-1:0] rel_x;
  logic [RY_W-1:0] rel_y;
  logic            in_board_c, grid_c;
  logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] mem_addr_d, mem_addr_q;

  assign rel_x = RX_W'(hcount_in - X_LO);
  assign rel_y = RY_W'(vcount_in - Y_LO);

  // Bounds are tested on the raw counters so pixels left/above the board
  // cannot wrap into it through the subtraction.
  assign in_board_c = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                      (vcount_in >= Y_LO) && (vcount_in < Y_HI);

  assign grid_c = in_board_c &&
                  ((rel_x[CELL_SHIFT-1:0] == '0) || (rel_y[CELL_SHIFT-1:0] == '0));

  assign mem_addr_d = in_board_c ?
                      {rel_y[CELL_SHIFT +: Y_ADDR_WIDTH], rel_x[CELL_SHIFT +: X_ADDR_WIDTH]} :
                      '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_addr_q <= '0;
    else      mem_addr_q <= mem_addr_d;
  end

  assign mem_addr = mem_addr_q;

  // ------------- stages 1..MEM_LATENCY+1: ride along with the read -------------
  logic [TIM_W-1:0] tim_dly;
  logic [PIX_W-1:0] pix_dly;

  signal_delay #(.WIDTH(TIM_W), .CLK_DEL(MEM_LATENCY + 1)) u_tim_dly (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    ({vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in}),
    .q_o    (tim_dly)
  );

  signal_delay #(.WIDTH(PIX_W), .CLK_DEL(MEM_LATENCY + 1)) u_pix_dly (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    ({rgb_in, in_board_c, grid_c}),
    .q_o    (pix_dly)
  );

  logic [VGA_W-1:0] vcount_dly, hcount_dly;
  logic             vsync_dly, hsync_dly, vblnk_dly, hblnk_dly;
  logic [11:0]      rgb_dly;
  logic             in_board_dly, grid_dly;

  assign {vcount_dly, hcount_dly, vsync_dly, hsync_dly, vblnk_dly, hblnk_dly} = tim_dly;
  assign {rgb_dly, in_board_dly, grid_dly} = pix_dly;

  // ---------------- final stage: colour select ----------------
  logic [11:0] rgb_d, rgb_q;
  logic [VGA_W-1:0] vcount_q, hcount_q;
  logic vsync_q, hsync_q, vblnk_q, hblnk_q;

  always_comb begin
    rgb_d = rgb_dly;
    if (hblnk_dly || vblnk_dly) begin
      rgb_d = 12'h000;
    end else if (!in_board_dly) begin
      rgb_d = rgb_dly;
    end else if (grid_dly) begin
      rgb_d = C_GRID;
    end else begin
      case (cell_state_t'(mem_data))
        EMPTY:   rgb_d = C_EMPTY;
        SHIP:    rgb_d = C_SHIP;
        HIT:     rgb_d = C_HIT;
        MISS:    rgb_d = C_MISS;
        default: rgb_d = C_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q    <= '0;
      vcount_q <= '0;
      hcount_q <= '0;
      vsync_q  <= 1'b0;
      hsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      hblnk_q  <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      vcount_q <= vcount_dly;
      hcount_q <= hcount_dly;
      vsync_q  <= vsync_dly;
      hsync_q  <= hsync_dly;
      vblnk_q  <= vblnk_dly;
      hblnk_q  <= hblnk_dly;
    end
  end

  assign rgb_out    = rgb_q;
  assign vcount_out = vcount_q;
  assign hcount_out = hcount_q;
  assign vsync_out  = vsync_q;
  assign hsync_out  = hsync_q;
  assign vblnk_out  = vblnk_q;
  assign hblnk_out  = hblnk_q;

endmodule

// File: tb/tb_board_draw.sv
// tb_board_draw: directed + random pixels against a pixel-level model of
// the board overlay, with a 1-clock-latency board memory.
module tb_board_draw;

  localparam int BX = 64, BY = 64, CS = 32, NC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 0, hsync_in = 0, vblnk_in = 0, hblnk_in = 0;
  logic [11:0] rgb_in = '0;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_data;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  board_draw dut (
    .clk(clk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out)
  );

  // board memory: data one clock after the address
  logic [1:0] mem [256];
  always @(posedge clk) mem_data <= mem[mem_addr];

  typedef struct {
    int          h, v;
    logic [11:0] rgb;
    logic        hs, vs, hb, vb, r;
  } pix_t;

  pix_t hist[$];
  int   n_chk = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit on_board(pix_t p);
    return p.h >= BX && p.h < BX + NC*CS && p.v >= BY && p.v < BY + NC*CS;
  endfunction

  function automatic logic [7:0] ref_addr(pix_t p);
    if (!on_board(p)) return 8'h00;
    return 8'(((p.v - BY) / CS) * NC + (p.h - BX) / CS);
  endfunction

  function automatic logic [11:0] ref_rgb(pix_t p);
    if (p.hb || p.vb) return 12'h000;
    if (!on_board(p)) return p.rgb;
    if ((p.h - BX) % CS == 0 || (p.v - BY) % CS == 0) return 12'h000;
    case (mem[ref_addr(p)])
      2'd0:    return 12'h08F;
      2'd1:    return 12'h888;
      2'd2:    return 12'hF00;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic pix_t mk(int h, int v, logic [11:0] c, logic hb, logic vb, logic r);
    pix_t p;
    p.h = h; p.v = v; p.rgb = c; p.hs = 0; p.vs = 0; p.hb = hb; p.vb = vb; p.r = r;
    return p;
  endfunction

  // At each falling edge: check outputs of the last rising edge, then drive
  // the next pixel. Output after edge n reflects the pixel sampled at n-2.
  task automatic step(pix_t p);
    int   n;
    bit   rz;
    pix_t q;
    logic prev_r;
    @(negedge clk);
    n = hist.size();
    if (n >= 3) begin
      q  = hist[n-3];
      rz = !(hist[n-1].r && hist[n-2].r && hist[n-3].r);
      chk("rgb_out",    rgb_out,    rz ? 64'(0) : 64'(ref_rgb(q)));
      chk("hcount_out", hcount_out, rz ? 64'(0) : 64'(q.h));
      chk("vcount_out", vcount_out, rz ? 64'(0) : 64'(q.v));
      chk("timing_out", {vsync_out, hsync_out, vblnk_out, hblnk_out},
          rz ? 64'(0) : 64'({q.vs, q.hs, q.vb, q.hb}));
    end
    if (n >= 1)
      chk("mem_addr", mem_addr, hist[n-1].r ? 64'(ref_addr(hist[n-1])) : 64'(0));
    prev_r    = rst;
    hcount_in = 11'(p.h);
    vcount_in = 11'(p.v);
    rgb_in    = p.rgb;
    hsync_in  = p.hs; vsync_in = p.vs; hblnk_in = p.hb; vblnk_in = p.vb;
    rst       = p.r;
    hist.push_back(p);
    if (prev_r && !p.r) begin
      #1;
      chk("async_reset", {rgb_out, hcount_out, vcount_out,
                          vsync_out, hsync_out, vblnk_out, hblnk_out, mem_addr}, 64'(0));
    end
  endtask

  initial begin
    pix_t p;
    int   edges[8];
    logic hs, vs;
    edges = '{63, 64, 65, 95, 96, 575, 576, 577};
    hs = 0; vs = 0;

    for (int i = 0; i < 256; i++) mem[i] = 2'($urandom);
    mem[8'h23] = 2'd2;
    mem[8'h00] = 2'd0;
    mem[8'h11] = 2'd1;
    mem[8'h45] = 2'd3;

    // reset held with an active pixel, then released
    for (int i = 0; i < 4; i++) step(mk(165, 135, 12'hABC, 0, 0, 0));
    step(mk(165, 135, 12'hABC, 0, 0, 1));
    step(mk(70, 70, 12'h123, 0, 0, 1));     // EMPTY
    step(mk(101, 101, 12'h123, 0, 0, 1));   // SHIP
    step(mk(229, 197, 12'h123, 0, 0, 1));   // MISS
    step(mk(96, 200, 12'h123, 0, 0, 1));    // vertical grid line
    step(mk(200, 64, 12'h123, 0, 0, 1));    // horizontal grid line
    step(mk(575, 300, 12'hABC, 0, 0, 1));   // last column
    step(mk(576, 300, 12'hABC, 0, 0, 1));   // right of board
    step(mk(63, 300, 12'hABC, 0, 0, 1));    // left of board
    step(mk(300, 575, 12'hABC, 0, 0, 1));   // last row
    step(mk(300, 63, 12'hABC, 0, 0, 1));    // above board
    step(mk(165, 135, 12'hABC, 1, 0, 1));   // hblank inside board
    step(mk(165, 135, 12'hABC, 0, 1, 1));   // vblank inside board
    step(mk(2000, 2000, 12'h5A5, 0, 0, 1)); // far outside, high counter bits
    step(mk(165, 135, 12'hABC, 0, 0, 0));   // mid-line reset
    step(mk(165, 135, 12'hABC, 0, 0, 0));
    for (int i = 0; i < 5; i++) step(mk(165, 135, 12'hABC, 0, 0, 1));

    // random pixels, boundary-biased, with sync pulses of random width
    for (int i = 0; i < 3000; i++) begin
      p.h   = ($urandom % 4 == 0) ? edges[$urandom % 8] : int'($urandom_range(0, 700));
      p.v   = ($urandom % 4 == 0) ? edges[$urandom % 8] : int'($urandom_range(0, 700));
      p.rgb = 12'($urandom);
      if ($urandom % 6 == 0) hs = ~hs;
      if ($urandom % 9 == 0) vs = ~vs;
      p.hs  = hs;
      p.vs  = vs;
      p.hb  = ($urandom % 10 == 0);
      p.vb  = ($urandom % 12 == 0);
      p.r   = ($urandom % 250 != 0);
      step(p);
    end
    for (int i = 0; i < 4; i++) step(mk(0, 0, 12'h000, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/board_draw.md
Name: board_draw

Overview:
- Display-side reader of the dual-port board memory: drives the memory's clk2 read port from the VGA pixel counters.
- Converts each 2-bit cell state into a colour and overlays the 16x16 board onto the incoming VGA stream at a fixed screen position.
- Sits in the 65 MHz VGA pipeline between the timing/background stage and the next draw stage.
- Delays the timing signals so they stay aligned with the colour output.

Parameters:
- X_POS, 64, board left edge in pixels
- Y_POS, 64, board top edge in pixels
- CELL_SIZE, 32, cell edge in pixels; must be a power of 2
- X_SIZE, 16, cells per row
- Y_SIZE, 16, cells per column
- X_ADDR_WIDTH, 4, column address bits
- Y_ADDR_WIDTH, 4, row address bits
- DATA_WIDTH, 2, cell state bits
- MEM_LATENCY, 1, clocks from address presented to read data valid

Ports:
- clk  in  1  65 MHz pixel clock; same clock as the memory clk2
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- vcount_in  in  11  vertical pixel counter
- hcount_in  in  11  horizontal pixel counter
- vsync_in, hsync_in, vblnk_in, hblnk_in  in  1 each  VGA timing
- rgb_in  in  12  upstream colour
- mem_addr  out  Y_ADDR_WIDTH+X_ADDR_WIDTH  read address {row, col}; row in the MSBs
- mem_data  in  DATA_WIDTH  memory read data
- vcount_out, hcount_out  out  11  delayed counters
- vsync_out, hsync_out, vblnk_out, hblnk_out  out  1 each  delayed timing
- rgb_out  out  12  output colour

Behaviour:
- Reset (rst=0), applied asynchronously:
  - all outputs and internal pipeline registers go to 0, including mem_addr=0 and rgb_out=0.
- Stage 1 (registered):
  - rel_x = hcount_in - X_POS, rel_y = vcount_in - Y_POS, both 11-bit.
  - in_board = (hcount_in >= X_POS) && (hcount_in < X_POS+X_SIZE*CELL_SIZE), and the same test on the vertical axis.
  - mem_addr = {rel_y[log2(CELL_SIZE) +: Y_ADDR_WIDTH], rel_x[log2(CELL_SIZE) +: X_ADDR_WIDTH]} when in_board, else 0.
  - grid = in_board && (rel_x mod CELL_SIZE == 0 || rel_y mod CELL_SIZE == 0).
- Stages 2..MEM_LATENCY+1: in_board, grid, rgb, counters and timing are delayed alongside the memory read.
- Final stage (registered), first matching rule wins:
  - blank (hblnk||vblnk) -> 12'h000
  - !in_board -> delayed rgb_in
  - grid -> 12'h000
  - EMPTY -> 12'h08F; SHIP -> 12'h888; HIT -> 12'hF00; MISS -> 12'hFFF
- Latency:
  - every output equals the corresponding input delayed by exactly MEM_LATENCY+2 clocks (3 at default).
  - mem_addr is 1 clock after its input.
- Boundaries:
  - hcount_in = X_POS+X_SIZE*CELL_SIZE-1 maps to the last column (15).
  - hcount_in = X_POS+X_SIZE*CELL_SIZE is outside the board.
  - hcount_in = X_POS-1 is outside the board.
  - hcount_in < X_POS must not alias: the comparison is done on the unsigned 11-bit inputs, not on rel_x.
- No handshake with the memory:
  - the block reads every clock.
  - writes on port 1 become visible whenever the memory returns them; no coherence is required.
- Reset mid-frame:
  - outputs go to 0 immediately.
  - after release, outputs are valid after MEM_LATENCY+2 clocks.
  - no state persists across frames.

Decomposition:
- Package board_pkg:
  - cell_state_t enum: EMPTY=0, SHIP=1, HIT=2, MISS=3
  - colour constants: C_EMPTY, C_SHIP, C_HIT, C_MISS, C_GRID
  - VGA counter width constant: 11
- Sub-module signal_delay (params WIDTH, CLK_DEL), shift-register delay with async active-low reset:
  - instantiated for the timing and counter bundle, and for rgb/in_board/grid.

Test Plan (defaults; the memory model returns data 1 clock after the address):
- Reset: hold rst=0 with active inputs -> all outputs 0 and mem_addr 0. Release rst -> first valid output 3 clocks later.
- Address/colour:
  - Stimulus: hcount=165, vcount=135, not blank.
  - mem_addr=8'h23 after 1 clock.
  - Model returns 2'd2 -> rgb_out=12'hF00 and hcount_out=165 after 3 clocks.
- Colour map: cells loaded with 0/1/3 -> 12'h08F / 12'h888 / 12'hFFF at the matching pixels.
- Grid: hcount=96 or vcount=64 inside the board -> rgb_out=12'h000 whatever the data.
- Edges:
  - hcount=575 -> column 15, board colour.
  - hcount=576 and hcount=63 -> rgb_out = rgb_in (e.g. 12'hABC) after 3 clocks.
  - vcount=575 -> row 15.
- Blanking and syncs:
  - hblnk=1 inside the board -> rgb_out=0.
  - a hsync/vsync pulse of any length appears with identical width exactly 3 clocks later.
  - reset asserted mid-line -> immediate zeros, clean recovery.
